// File: rtl/slice_mux_pipe.sv
// rtl/slice_mux_pipe.sv - two-stage valid/ready 8:1 wide mux (F5/F6 then F7) with clock enable
module slice_mux_pipe #(
  parameter int            W    = 4,
  parameter logic [W-1:0]  INIT = {W{1'b0}}
) (
  input  logic           C,
  input  logic           R,
  input  logic           CE,
  input  logic           VI,
  output logic           RI,
  input  logic [8*W-1:0] I,
  input  logic [2:0]     S,
  output logic           VO,
  input  logic           RO,
  output logic [W-1:0]   O
);

  logic [W-1:0] w_lane [8];
  logic [W-1:0] w_lo;
  logic [W-1:0] w_hi;
  logic         w_ld1;
  logic         w_ld2;

  logic         r_s1_v;
  logic [W-1:0] r_s1_lo;
  logic [W-1:0] r_s1_hi;
  logic         r_s1_sel;
  logic         r_vo;
  logic [W-1:0] r_o;

  for (genvar k = 0; k < 8; k++) begin : g_lane
    assign w_lane[k] = I[k*W +: W];
  end

  // Both F6 halves are resolved up front so stage 2 only needs the F7 pick.
  assign w_lo  = w_lane[{1'b0, S[1:0]}];
  assign w_hi  = w_lane[{1'b1, S[1:0]}];

  assign w_ld2 = CE & (~r_vo | RO);
  assign w_ld1 = CE & (~r_s1_v | w_ld2);
  assign RI    = w_ld1;
  assign VO    = r_vo;
  assign O     = r_o;

  always_ff @(posedge C) begin
    if (R) begin
      r_s1_v   <= 1'b0;
      r_s1_lo  <= {W{1'b0}};
      r_s1_hi  <= {W{1'b0}};
      r_s1_sel <= 1'b0;
      r_vo     <= 1'b0;
      r_o      <= INIT;
    end else begin
      if (w_ld1) begin
        r_s1_v <= VI;
        if (VI) begin
          r_s1_lo  <= w_lo;
          r_s1_hi  <= w_hi;
          r_s1_sel <= S[2];
        end
      end
      // A bubble moving into stage 2 clears VO but leaves O untouched.
      if (w_ld2) begin
        r_vo <= r_s1_v;
        if (r_s1_v) begin
          r_o <= r_s1_sel ? r_s1_hi : r_s1_lo;
        end
      end
    end
  end

endmodule
